// File: rtl/mem_param.sv
`default_nettype none
// ============================================================================
// Module   : mem_param
// Desc     : Parametrised single-port RAM with byte-enable writes, registered
//            read with valid strobe, post-reset clear sweep and error flag.
//            Optional define MEM_BYPASS_EN: write-first forwarding when a
//            write and a read hit the same address in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] Datain,
  output logic [DATA_W-1:0] Dataout,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_err;
  logic              w_ready;
  logic              w_addr_ok;
  logic              w_do_wr;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_rd_word;

  assign w_ready   = (r_state == ST_READY);
  assign w_addr_ok = ({1'b0, addr} < c_DEPTH);
  assign w_do_wr   = w_ready && wr && w_addr_ok;
  assign w_old     = r_mem[addr];

`ifdef MEM_BYPASS_EN
  for (genvar k = 0; k < BE_W; k++) begin : g_byp
    assign w_rd_word[8*k +: 8] = (w_do_wr && be[k]) ? Datain[8*k +: 8] : w_old[8*k +: 8];
  end
`else
  assign w_rd_word = w_old;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (r_cnt == c_LAST) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_INIT);
      if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Contents survive rst; only the sweep (rst low, INIT) zeroes them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_ready) begin
        r_mem[r_cnt] <= '0;
      end else if (w_do_wr) begin
        for (int k = 0; k < BE_W; k++) begin
          if (be[k]) r_mem[addr][8*k +: 8] <= Datain[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err      <= (wr || rd) && !(w_ready && w_addr_ok);
      r_rd_valid <= w_ready && rd;
      if (w_ready && rd) r_dout <= w_addr_ok ? w_rd_word : '0;
    end
  end

  assign Dataout  = r_dout;
  assign rd_valid = r_rd_valid;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
`default_nettype wire
